// File: rtl/axi_rd_arb.sv
// axi_rd_arb: two-requester read arbiter in front of the LSU-side AXI read port.
// One requester owns the port for a whole transfer: the AR is issued once and
// arnum bursts of R beats (arnum==0 counts as one) are routed back to the owner.
// Round-robin priority applies when both requesters are waiting.
module axi_rd_arb #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 64,
   parameter int ID_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   // requester 0
   input  logic              r0_arvld,
   input  logic [ADDR_W-1:0] r0_araddr,
   input  logic [ID_W-1:0]   r0_arid,
   input  logic [7:0]        r0_arlen,
   input  logic [2:0]        r0_arsize,
   input  logic [1:0]        r0_arburst,
   input  logic [2:0]        r0_arstr,
   input  logic [7:0]        r0_arnum,
   output logic              r0_arrdy,
   output logic              r0_rvld,
   output logic [DATA_W-1:0] r0_rdata,
   output logic [ID_W-1:0]   r0_rid,
   output logic [1:0]        r0_rresp,
   output logic              r0_rlast,
   input  logic              r0_rrdy,
   // requester 1
   input  logic              r1_arvld,
   input  logic [ADDR_W-1:0] r1_araddr,
   input  logic [ID_W-1:0]   r1_arid,
   input  logic [7:0]        r1_arlen,
   input  logic [2:0]        r1_arsize,
   input  logic [1:0]        r1_arburst,
   input  logic [2:0]        r1_arstr,
   input  logic [7:0]        r1_arnum,
   output logic              r1_arrdy,
   output logic              r1_rvld,
   output logic [DATA_W-1:0] r1_rdata,
   output logic [ID_W-1:0]   r1_rid,
   output logic [1:0]        r1_rresp,
   output logic              r1_rlast,
   input  logic              r1_rrdy,
   // read interface, address channel
   output logic              arb_axi_arvld,
   output logic [ADDR_W-1:0] arb_axi_araddr,
   output logic [ID_W-1:0]   arb_axi_arid,
   output logic [7:0]        arb_axi_arlen,
   output logic [2:0]        arb_axi_arsize,
   output logic [1:0]        arb_axi_arburst,
   output logic [2:0]        arb_axi_arstr,
   output logic [7:0]        arb_axi_arnum,
   input  logic              axi_arb_arrdy,
   // read interface, data channel
   input  logic              axi_arb_rvld,
   input  logic [DATA_W-1:0] axi_arb_rdata,
   input  logic [ID_W-1:0]   axi_arb_rid,
   input  logic [1:0]        axi_arb_rresp,
   input  logic              axi_arb_rlast,
   output logic              arb_axi_rrdy,
   // status
   output logic              arb_busy,
   output logic              arb_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t            state_r;
   logic              last_gnt_r;
   logic              owner_r;
   logic [7:0]        burst_left_r;
   logic              err_acc_r;
   logic              arb_err_r;
   logic              arvld_r;
   logic [ADDR_W-1:0] addr_r;
   logic [ID_W-1:0]   id_r;
   logic [7:0]        len_r;
   logic [2:0]        size_r;
   logic [1:0]        burst_r;
   logic [2:0]        str_r;
   logic [7:0]        num_r;

   logic              gnt0_s;
   logic              gnt1_s;
   logic              route0_s;
   logic              route1_s;
   logic              owner_rrdy_s;
   logic              beat_s;
   logic              beat_err_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [ID_W-1:0]   sel_id_s;
   logic [7:0]        sel_len_s;
   logic [2:0]        sel_size_s;
   logic [1:0]        sel_burst_s;
   logic [2:0]        sel_str_s;
   logic [7:0]        sel_num_s;

   // Grant decision in IDLE; when both ask, the requester not served last wins.
   // Grants are suppressed while reset is asserted so arrdy stays low.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if ((state_r == IDLE) && rst_n) begin
         if (r0_arvld && r1_arvld) begin
            gnt0_s = last_gnt_r;
            gnt1_s = ~last_gnt_r;
         end else begin
            gnt0_s = r0_arvld;
            gnt1_s = r1_arvld;
         end
      end else begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end
   end

   // Select the request fields of the granted requester for latching.
   always_comb begin
      if (gnt1_s) begin
         sel_addr_s  = r1_araddr;
         sel_id_s    = r1_arid;
         sel_len_s   = r1_arlen;
         sel_size_s  = r1_arsize;
         sel_burst_s = r1_arburst;
         sel_str_s   = r1_arstr;
         sel_num_s   = r1_arnum;
      end else begin
         sel_addr_s  = r0_araddr;
         sel_id_s    = r0_arid;
         sel_len_s   = r0_arlen;
         sel_size_s  = r0_arsize;
         sel_burst_s = r0_arburst;
         sel_str_s   = r0_arstr;
         sel_num_s   = r0_arnum;
      end
   end

   // R-channel routing: only the owner sees beats, and only in WAIT.
   always_comb begin
      route0_s     = (state_r == WAIT) && (owner_r == 1'b0);
      route1_s     = (state_r == WAIT) && (owner_r == 1'b1);
      if (owner_r) begin
         owner_rrdy_s = r1_rrdy;
      end else begin
         owner_rrdy_s = r0_rrdy;
      end
      beat_s     = axi_arb_rvld && (route0_s || route1_s) && owner_rrdy_s;
      beat_err_s = (axi_arb_rresp != 2'b00);
   end

   // Transfer FSM: grant/latch in IDLE, hold AR in ISSUE, count bursts in WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         last_gnt_r   <= 1'b1;
         owner_r      <= 1'b0;
         burst_left_r <= 8'd0;
         err_acc_r    <= 1'b0;
         arb_err_r    <= 1'b0;
         arvld_r      <= 1'b0;
         addr_r       <= {ADDR_W{1'b0}};
         id_r         <= {ID_W{1'b0}};
         len_r        <= 8'd0;
         size_r       <= 3'd0;
         burst_r      <= 2'd0;
         str_r        <= 3'd0;
         num_r        <= 8'd0;
      end else begin
         arb_err_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (gnt0_s || gnt1_s) begin
                  owner_r <= gnt1_s;
                  addr_r  <= sel_addr_s;
                  id_r    <= sel_id_s;
                  len_r   <= sel_len_s;
                  size_r  <= sel_size_s;
                  burst_r <= sel_burst_s;
                  str_r   <= sel_str_s;
                  num_r   <= sel_num_s;
                  arvld_r <= 1'b1;
                  state_r <= ISSUE;
               end
            end
            ISSUE: begin
               if (arvld_r && axi_arb_arrdy) begin
                  burst_left_r <= (num_r == 8'd0) ? 8'd1 : num_r;
                  err_acc_r    <= 1'b0;
                  arvld_r      <= 1'b0;
                  state_r      <= WAIT;
               end
            end
            WAIT: begin
               if (beat_s) begin
                  if (beat_err_s) begin
                     err_acc_r <= 1'b1;
                  end
                  if (axi_arb_rlast) begin
                     if (burst_left_r >= 8'd1) begin
                        burst_left_r <= burst_left_r - 8'd1;
                     end
                     if (burst_left_r <= 8'd1) begin
                        state_r    <= IDLE;
                        last_gnt_r <= owner_r;
                        arb_err_r  <= err_acc_r | beat_err_s;
                     end
                  end
               end
            end
            default: begin
               state_r <= IDLE;
               arvld_r <= 1'b0;
            end
         endcase
      end
   end

   assign r0_arrdy        = gnt0_s;
   assign r1_arrdy        = gnt1_s;
   assign arb_axi_arvld   = arvld_r;
   assign arb_axi_araddr  = addr_r;
   assign arb_axi_arid    = id_r;
   assign arb_axi_arlen   = len_r;
   assign arb_axi_arsize  = size_r;
   assign arb_axi_arburst = burst_r;
   assign arb_axi_arstr   = str_r;
   assign arb_axi_arnum   = num_r;
   assign arb_axi_rrdy    = (route0_s || route1_s) && owner_rrdy_s;
   assign r0_rvld         = route0_s && axi_arb_rvld;
   assign r1_rvld         = route1_s && axi_arb_rvld;
   assign r0_rdata        = route0_s ? axi_arb_rdata : {DATA_W{1'b0}};
   assign r1_rdata        = route1_s ? axi_arb_rdata : {DATA_W{1'b0}};
   assign r0_rid          = route0_s ? axi_arb_rid : {ID_W{1'b0}};
   assign r1_rid          = route1_s ? axi_arb_rid : {ID_W{1'b0}};
   assign r0_rresp        = route0_s ? axi_arb_rresp : 2'b00;
   assign r1_rresp        = route1_s ? axi_arb_rresp : 2'b00;
   assign r0_rlast        = route0_s && axi_arb_rlast;
   assign r1_rlast        = route1_s && axi_arb_rlast;
   assign arb_busy        = (state_r != IDLE);
   assign arb_err         = arb_err_r;

endmodule

// File: tb/tb_axi_rd_arb.sv
// tb_axi_rd_arb: randomized scoreboard bench for axi_rd_arb. A transaction-level
// model predicts grant order, the AR each requester should issue and the beats
// each requester should receive; a monitor compares against the DUT.
module tb_axi_rd_arb;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 64;
   localparam int ID_W   = 8;

   typedef struct packed {
      logic              owner;
      logic [ADDR_W-1:0] addr;
      logic [ID_W-1:0]   id;
      logic [7:0]        len;
      logic [2:0]        size;
      logic [1:0]        burst;
      logic [2:0]        str;
      logic [7:0]        num;
   } xfer_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ID_W-1:0]   id;
      logic [1:0]        resp;
      logic              last;
      logic              fin;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]        req_vld = 2'b00;
   xfer_t             reqf [2];
   logic              r0_arrdy, r1_arrdy, r0_rvld, r1_rvld, r0_rlast, r1_rlast;
   logic [DATA_W-1:0] r0_rdata, r1_rdata;
   logic [ID_W-1:0]   r0_rid, r1_rid;
   logic [1:0]        r0_rresp, r1_rresp;
   logic              r0_rrdy = 1'b0, r1_rrdy = 1'b0;
   logic              arb_axi_arvld, arb_axi_rrdy, arb_busy, arb_err;
   logic [ADDR_W-1:0] arb_axi_araddr;
   logic [ID_W-1:0]   arb_axi_arid;
   logic [7:0]        arb_axi_arlen, arb_axi_arnum;
   logic [2:0]        arb_axi_arsize, arb_axi_arstr;
   logic [1:0]        arb_axi_arburst;
   logic              axi_arb_arrdy = 1'b0;
   logic              axi_arb_rvld = 1'b0;
   logic [DATA_W-1:0] axi_arb_rdata = '0;
   logic [ID_W-1:0]   axi_arb_rid = '0;
   logic [1:0]        axi_arb_rresp = 2'b00;
   logic              axi_arb_rlast = 1'b0;

   axi_rd_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_arvld(req_vld[0]), .r0_araddr(reqf[0].addr), .r0_arid(reqf[0].id),
      .r0_arlen(reqf[0].len), .r0_arsize(reqf[0].size), .r0_arburst(reqf[0].burst),
      .r0_arstr(reqf[0].str), .r0_arnum(reqf[0].num), .r0_arrdy(r0_arrdy),
      .r0_rvld(r0_rvld), .r0_rdata(r0_rdata), .r0_rid(r0_rid), .r0_rresp(r0_rresp),
      .r0_rlast(r0_rlast), .r0_rrdy(r0_rrdy),
      .r1_arvld(req_vld[1]), .r1_araddr(reqf[1].addr), .r1_arid(reqf[1].id),
      .r1_arlen(reqf[1].len), .r1_arsize(reqf[1].size), .r1_arburst(reqf[1].burst),
      .r1_arstr(reqf[1].str), .r1_arnum(reqf[1].num), .r1_arrdy(r1_arrdy),
      .r1_rvld(r1_rvld), .r1_rdata(r1_rdata), .r1_rid(r1_rid), .r1_rresp(r1_rresp),
      .r1_rlast(r1_rlast), .r1_rrdy(r1_rrdy),
      .arb_axi_arvld(arb_axi_arvld), .arb_axi_araddr(arb_axi_araddr),
      .arb_axi_arid(arb_axi_arid), .arb_axi_arlen(arb_axi_arlen),
      .arb_axi_arsize(arb_axi_arsize), .arb_axi_arburst(arb_axi_arburst),
      .arb_axi_arstr(arb_axi_arstr), .arb_axi_arnum(arb_axi_arnum),
      .axi_arb_arrdy(axi_arb_arrdy),
      .axi_arb_rvld(axi_arb_rvld), .axi_arb_rdata(axi_arb_rdata), .axi_arb_rid(axi_arb_rid),
      .axi_arb_rresp(axi_arb_rresp), .axi_arb_rlast(axi_arb_rlast),
      .arb_axi_rrdy(arb_axi_rrdy), .arb_busy(arb_busy), .arb_err(arb_err)
   );

   int    errors = 0;
   int    checks = 0;
   int    ar_cnt = 0;
   bit    mlast = 1'b1;          // model: requester served last (1 => r0 wins a tie)
   bit    slave_hold = 1'b0;
   xfer_t exp_ar_q [$];
   xfer_t slave_q [$];
   beat_t exp_r0_q [$];
   beat_t exp_r1_q [$];
   bit    exp_err_q [$];

   // slave state
   bit    s_have = 1'b0, s_pres = 1'b0, s_acc = 1'b0;
   int    s_beat = 0, s_burst = 0;
   xfer_t s_x;
   beat_t s_b;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   function automatic xfer_t rnd_req();
      xfer_t x;
      x.owner = 1'b0;
      x.addr  = ADDR_W'($urandom);
      x.id    = ID_W'($urandom);
      x.len   = 8'($urandom_range(0, 3));
      x.size  = 3'($urandom);
      x.burst = 2'($urandom);
      x.str   = 3'($urandom);
      x.num   = 8'($urandom_range(0, 3));
      return x;
   endfunction

   function automatic logic [41:0] ar_of(input xfer_t x);
      return {x.addr, x.id, x.len, x.size, x.burst, x.str, x.num};
   endfunction

   // random back-pressure on requesters and the AR channel
   initial forever begin
      @(posedge clk); #1;
      r0_rrdy       = ($urandom_range(0, 3) != 0);
      r1_rrdy       = ($urandom_range(0, 3) != 0);
      axi_arb_arrdy = ($urandom_range(0, 2) == 0);
   end

   // read-interface slave: plays back arnum bursts of arlen+1 beats per accepted AR
   initial begin
      bit hs;
      int nb;
      forever begin
         @(negedge clk);
         hs = axi_arb_rvld && arb_axi_rrdy;
         @(posedge clk); #1;
         if (!rst_n) begin
            s_have = 1'b0; s_pres = 1'b0; axi_arb_rvld = 1'b0;
         end else begin
            if (s_pres && hs) begin
               s_pres = 1'b0;
               axi_arb_rvld = 1'b0;
               if (s_b.last) begin
                  s_beat = 0;
                  s_burst++;
                  if (s_b.fin) s_have = 1'b0;
               end else begin
                  s_beat++;
               end
            end
            if (!s_pres && !slave_hold) begin
               if (!s_have && slave_q.size() > 0) begin
                  s_x = slave_q.pop_front();
                  s_have = 1'b1; s_beat = 0; s_burst = 0; s_acc = 1'b0;
               end
               if (s_have && $urandom_range(0, 3) != 0) begin
                  nb = (s_x.num == 8'd0) ? 1 : int'(s_x.num);
                  s_b.data = {$urandom, $urandom};
                  s_b.id   = s_x.id;
                  s_b.resp = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00;
                  s_b.last = (s_beat == int'(s_x.len));
                  s_b.fin  = s_b.last && (s_burst == nb - 1);
                  if (s_x.owner) exp_r1_q.push_back(s_b);
                  else           exp_r0_q.push_back(s_b);
                  s_acc = s_acc | (s_b.resp != 2'b00);
                  if (s_b.fin) exp_err_q.push_back(s_acc);
                  axi_arb_rvld  = 1'b1;
                  axi_arb_rdata = s_b.data;
                  axi_arb_rid   = s_b.id;
                  axi_arb_rresp = s_b.resp;
                  axi_arb_rlast = s_b.last;
                  s_pres = 1'b1;
               end
            end
         end
      end
   end

   // monitor: AR stability and contents, per-requester beats, error pulse
   initial begin
      bit          ar_hold = 1'b0, err_pend = 1'b0, err_exp = 1'b0;
      logic [41:0] prev_ar = '0, ar_now;
      xfer_t       x;
      beat_t       b;
      forever begin
         @(negedge clk);
         ar_now = {arb_axi_araddr, arb_axi_arid, arb_axi_arlen, arb_axi_arsize,
                   arb_axi_arburst, arb_axi_arstr, arb_axi_arnum};
         if (!rst_n) begin
            ar_hold = 1'b0; err_pend = 1'b0;
         end else begin
            if (err_pend) chk("arb_err pulse", arb_err, err_exp);
            else          chk("arb_err quiet", arb_err, 1'b0);
            err_pend = 1'b0;
            if (ar_hold) begin
               chk("arvld held", arb_axi_arvld, 1'b1);
               chk("ar stable", ar_now, prev_ar);
            end
            ar_hold = arb_axi_arvld && !axi_arb_arrdy;
            prev_ar = ar_now;
            if (arb_axi_arvld && axi_arb_arrdy) begin
               if (exp_ar_q.size() == 0) fail_now("unexpected AR");
               else begin
                  x = exp_ar_q.pop_front();
                  chk("ar fields", ar_now, ar_of(x));
                  slave_q.push_back(x);
                  ar_cnt++;
               end
            end
            if (r0_rvld && exp_r0_q.size() == 0) fail_now("r0 stray rvld");
            else if (r0_rvld && r0_rrdy) begin
               b = exp_r0_q.pop_front();
               chk("r0 beat", {r0_rdata, r0_rid, r0_rresp, r0_rlast}, {b.data, b.id, b.resp, b.last});
               if (b.fin) begin err_pend = 1'b1; err_exp = exp_err_q.pop_front(); end
            end
            if (r1_rvld && exp_r1_q.size() == 0) fail_now("r1 stray rvld");
            else if (r1_rvld && r1_rrdy) begin
               b = exp_r1_q.pop_front();
               chk("r1 beat", {r1_rdata, r1_rid, r1_rresp, r1_rlast}, {b.data, b.id, b.resp, b.last});
               if (b.fin) begin err_pend = 1'b1; err_exp = exp_err_q.pop_front(); end
            end
         end
      end
   end

   // Issue requests for the requesters in mode; predict each grant. Starts and ends at posedge+1.
   task automatic do_round(input int mode);
      bit    pend [2];
      bit    rere = 1'b0, jg = 1'b0;
      int    w, budget = 3000;
      xfer_t x;
      for (int i = 0; i < 2; i++) begin
         pend[i] = ((mode >> i) & 1) != 0;
         if (pend[i]) begin reqf[i] = rnd_req(); req_vld[i] = 1'b1; end
      end
      while ((pend[0] || pend[1]) && budget > 0) begin
         @(negedge clk);
         if (jg) begin
            chk("arvld latency", arb_axi_arvld, 1'b1);
            chk("busy after grant", arb_busy, 1'b1);
            jg = 1'b0;
         end
         w = -1;
         if (r0_arrdy || r1_arrdy) begin
            w = (pend[0] && pend[1]) ? (mlast ? 0 : 1) : (pend[0] ? 0 : 1);
            chk("grant r0", r0_arrdy, w == 0);
            chk("grant r1", r1_arrdy, w == 1);
            x = reqf[w];
            x.owner = w[0];
            exp_ar_q.push_back(x);
            pend[w] = 1'b0;
            mlast = w[0];
         end
         @(posedge clk); #1;
         if (w >= 0) begin
            jg = 1'b1;
            req_vld[w] = 1'b0;
            if (!rere && pend[1-w] && $urandom_range(0, 1) == 1) begin
               rere = 1'b1;
               reqf[w] = rnd_req();
               req_vld[w] = 1'b1;
               pend[w] = 1'b1;
            end
         end
         budget--;
      end
      if (budget == 0) fail_now("grant timeout");
      if (jg) begin
         @(negedge clk);
         chk("arvld latency", arb_axi_arvld, 1'b1);
         @(posedge clk); #1;
      end
   endtask

   task automatic drain();
      int budget = 5000;
      while ((exp_ar_q.size() > 0 || slave_q.size() > 0 || s_have || exp_r0_q.size() > 0 ||
              exp_r1_q.size() > 0 || arb_busy) && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      if (budget == 0) fail_now("drain timeout");
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int c, budget;
      reqf[0] = '0;
      reqf[1] = '0;
      req_vld = 2'b11;
      repeat (3) @(negedge clk);
      chk("reset arrdy", {r0_arrdy, r1_arrdy}, 2'b00);
      chk("reset arvld", arb_axi_arvld, 1'b0);
      chk("reset busy", arb_busy, 1'b0);
      chk("reset rrdy", arb_axi_rrdy, 1'b0);
      req_vld = 2'b00;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle busy", arb_busy, 1'b0);

      do_round(3);
      for (int n = 0; n < 30; n++) begin
         do_round($urandom_range(1, 3));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      drain();

      // reset in the middle of a transfer
      slave_hold = 1'b1;
      c = ar_cnt;
      do_round(1);
      budget = 200;
      while (ar_cnt == c && budget > 0) begin @(posedge clk); #1; budget--; end
      if (budget == 0) fail_now("AR timeout before reset");
      repeat (2) @(posedge clk);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("async rst busy", arb_busy, 1'b0);
      chk("async rst arvld", arb_axi_arvld, 1'b0);
      chk("async rst rrdy", arb_axi_rrdy, 1'b0);
      chk("async rst rvld", {r0_rvld, r1_rvld}, 2'b00);
      chk("async rst err", arb_err, 1'b0);
      exp_ar_q.delete(); slave_q.delete(); exp_r0_q.delete(); exp_r1_q.delete(); exp_err_q.delete();
      mlast = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      slave_hold = 1'b0;
      @(posedge clk); #1;
      do_round(3);
      drain();
      chk("final busy", arb_busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
